// File: rtl/aud_pkg.sv
// Shared types and widths for the audio mode controller.
package aud_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned SPD_W  = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REC        = 3'd1,
        REC_PAUSE  = 3'd2,
        PLAY       = 3'd3,
        PLAY_PAUSE = 3'd4
    } aud_state_e;

endpackage

// File: rtl/aud_play_addr_gen.sv
// Playback address generator: detects I2S frame ticks, steps the read address
// fast (multi-word jumps) or slow (one word every N frames), and flags the end
// of the recorded region.
module aud_play_addr_gen #(
    parameter int unsigned ADDR_W = aud_pkg::ADDR_W,
    parameter int unsigned SPD_W  = aud_pkg::SPD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_fast,
    input  logic [SPD_W-1:0]  i_speed,
    input  logic [ADDR_W-1:0] i_rec_len,
    output logic [ADDR_W-1:0] o_play_addr,
    output logic              o_done
);

    logic              lrc_q, lrc_d;
    logic              lrc_vld_q, lrc_vld_d;
    logic [SPD_W-1:0]  speed_q, speed_d;
    logic [SPD_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              tick;
    logic              speed_chg;
    logic [SPD_W-1:0]  cnt_eff;
    logic [ADDR_W:0]   spd_ext;
    logic [ADDR_W:0]   inc;
    logic [ADDR_W:0]   sum;
    logic              advance;
    logic              over;
    logic              done;

    // Tick detection, step size, end-of-record compare and next address/counter.
    always_comb begin
        lrc_d     = i_lrc;
        lrc_vld_d = 1'b1;
        speed_d   = i_speed;

        // lrc_vld_q masks the very first sample so reset never fakes an edge
        tick      = i_lrc & ~lrc_q & lrc_vld_q;
        speed_chg = (i_speed != speed_q);
        cnt_eff   = speed_chg ? '0 : cnt_q;

        spd_ext              = '0;
        spd_ext[SPD_W-1:0]   = i_speed;
        inc                  = i_fast ? (spd_ext + 1'b1) : {{ADDR_W{1'b0}}, 1'b1};
        // One extra bit so a jump past the top of the address space is still "over"
        sum                  = {1'b0, addr_q} + inc;
        advance              = i_fast | (cnt_eff == i_speed);
        over                 = (sum > {1'b0, i_rec_len});
        done                 = i_en & tick & advance & over;

        addr_d = addr_q;
        cnt_d  = cnt_eff;
        if (i_clr) begin
            addr_d = '0;
            cnt_d  = '0;
        end else if (i_en && tick) begin
            if (done) begin
                addr_d = '0;
                cnt_d  = '0;
            end else if (advance) begin
                addr_d = sum[ADDR_W-1:0];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_eff + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lrc_q     <= 1'b0;
            lrc_vld_q <= 1'b0;
            speed_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
        end else begin
            lrc_q     <= lrc_d;
            lrc_vld_q <= lrc_vld_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
        end
    end

    assign o_play_addr = addr_q;
    assign o_done      = done;

endmodule

// File: rtl/aud_mode_ctrl.sv
// Audio path sequencer: key pulses -> recorder start/pause/stop pulses, SRAM
// direction, recording length latch and playback address generation.
module aud_mode_ctrl #(
    parameter int unsigned       ADDR_W   = aud_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}},
    parameter int unsigned       SPD_W    = aud_pkg::SPD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_key_start,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic              i_mode,
    input  logic              i_fast,
    input  logic [SPD_W-1:0]  i_speed,
    input  logic [ADDR_W-1:0] i_rec_addr,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_sram_we_n,
    output logic              o_play_en,
    output logic [ADDR_W-1:0] o_play_addr,
    output logic [ADDR_W-1:0] o_rec_len,
    output logic [2:0]        o_state
);

    import aud_pkg::*;

    aud_state_e        state_q, state_d;
    logic              rec_start_q, rec_start_d;
    logic              rec_pause_q, rec_pause_d;
    logic              rec_stop_q, rec_stop_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic              play_en_q, play_en_d;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;

    logic              gen_clr;
    logic              gen_en;
    logic              play_done;

    assign gen_en = (state_q == PLAY);

    aud_play_addr_gen #(
        .ADDR_W (ADDR_W),
        .SPD_W  (SPD_W)
    ) u_play_addr_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_lrc       (i_lrc),
        .i_en        (gen_en),
        .i_clr       (gen_clr),
        .i_fast      (i_fast),
        .i_speed     (i_speed),
        .i_rec_len   (rec_len_q),
        .o_play_addr (o_play_addr),
        .o_done      (play_done)
    );

    // Next-state, pulse and length-latch decode; key priority stop > pause > start.
    always_comb begin
        state_d     = state_q;
        rec_start_d = 1'b0;
        rec_pause_d = 1'b0;
        rec_stop_d  = 1'b0;
        rec_len_d   = rec_len_q;
        gen_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!i_key_stop && !i_key_pause && i_key_start) begin
                    if (!i_mode) begin
                        state_d     = REC;
                        rec_start_d = 1'b1;
                    end else if (rec_len_q != '0) begin
                        state_d = PLAY;
                        gen_clr = 1'b1;
                    end
                end
            end
            REC: begin
                // Full SRAM ends the take exactly like a stop key
                if (i_key_stop || (i_rec_addr == MAX_ADDR)) begin
                    state_d    = IDLE;
                    rec_stop_d = 1'b1;
                    rec_len_d  = i_rec_addr;
                end else if (i_key_pause) begin
                    state_d     = REC_PAUSE;
                    rec_pause_d = 1'b1;
                end
            end
            REC_PAUSE: begin
                if (i_key_stop) begin
                    state_d    = IDLE;
                    rec_stop_d = 1'b1;
                    rec_len_d  = i_rec_addr;
                end else if (!i_key_pause && i_key_start) begin
                    state_d     = REC;
                    rec_start_d = 1'b1;
                end
            end
            PLAY: begin
                if (i_key_stop) begin
                    state_d = IDLE;
                    gen_clr = 1'b1;
                end else if (play_done) begin
                    state_d = IDLE;
                end else if (i_key_pause) begin
                    state_d = PLAY_PAUSE;
                end
            end
            PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_d = IDLE;
                    gen_clr = 1'b1;
                end else if (!i_key_pause && i_key_start) begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
                gen_clr = 1'b1;
            end
        endcase

        sram_we_n_d = (state_d != REC);
        play_en_d   = (state_d == PLAY);
    end

    // Registered state and outputs with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rec_start_q <= 1'b0;
            rec_pause_q <= 1'b0;
            rec_stop_q  <= 1'b0;
            sram_we_n_q <= 1'b1;
            play_en_q   <= 1'b0;
            rec_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            rec_start_q <= rec_start_d;
            rec_pause_q <= rec_pause_d;
            rec_stop_q  <= rec_stop_d;
            sram_we_n_q <= sram_we_n_d;
            play_en_q   <= play_en_d;
            rec_len_q   <= rec_len_d;
        end
    end

    assign o_rec_start = rec_start_q;
    assign o_rec_pause = rec_pause_q;
    assign o_rec_stop  = rec_stop_q;
    assign o_sram_we_n = sram_we_n_q;
    assign o_play_en   = play_en_q;
    assign o_rec_len   = rec_len_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed self-checking bench for aud_mode_ctrl.
module tb_aud_mode_ctrl;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned SPD_W  = 3;

    logic              clk;
    logic              rst;
    logic              lrc;
    logic              key_start, key_pause, key_stop;
    logic              mode, fast;
    logic [SPD_W-1:0]  speed;
    logic [ADDR_W-1:0] rec_addr;
    logic              rec_start, rec_pause, rec_stop;
    logic              sram_we_n, play_en;
    logic [ADDR_W-1:0] play_addr, rec_len;
    logic [2:0]        state;

    int n_tests = 0;
    int n_fail  = 0;

    aud_mode_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_lrc       (lrc),
        .i_key_start (key_start),
        .i_key_pause (key_pause),
        .i_key_stop  (key_stop),
        .i_mode      (mode),
        .i_fast      (fast),
        .i_speed     (speed),
        .i_rec_addr  (rec_addr),
        .o_rec_start (rec_start),
        .o_rec_pause (rec_pause),
        .o_rec_stop  (rec_stop),
        .o_sram_we_n (sram_we_n),
        .o_play_en   (play_en),
        .o_play_addr (play_addr),
        .o_rec_len   (rec_len),
        .o_state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic p, input logic t);
        key_start = s;
        key_pause = p;
        key_stop  = t;
        step();
        key_start = 1'b0;
        key_pause = 1'b0;
        key_stop  = 1'b0;
    endtask

    task automatic lrc_rise();
        lrc = 1'b0;
        step();
        lrc = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %0b want 1", sram_we_n); end
        n_tests++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL reset_play_en: got %0b want 0", play_en); end
        n_tests++; if (play_addr !== 20'd0) begin n_fail++; $display("FAIL reset_play_addr: got %0h want 0", play_addr); end
        n_tests++; if (rec_len !== 20'd0) begin n_fail++; $display("FAIL reset_rec_len: got %0h want 0", rec_len); end
        n_tests++; if ({rec_start, rec_pause, rec_stop} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %03b want 000", {rec_start, rec_pause, rec_stop}); end
    endtask

    task automatic test_reset_mid_rec();
        mode = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL midrec_enter: got %0d want 1", state); end
        rec_addr = 20'd100;
        step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++; if (rec_stop !== 1'b0) begin n_fail++; $display("FAIL midrec_no_stop: got %0b want 0", rec_stop); end
            n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL midrec_state: got %0d want 0", state); end
            n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL midrec_we_n: got %0b want 1", sram_we_n); end
        end
        rst = 1'b0;
        step();
        n_tests++; if (rec_len !== 20'd0) begin n_fail++; $display("FAIL midrec_rec_len: got %0h want 0", rec_len); end
        n_tests++; if (rec_stop !== 1'b0) begin n_fail++; $display("FAIL midrec_after: got %0b want 0", rec_stop); end
        rec_addr = 20'd0;
    endtask

    task automatic test_record();
        mode = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (rec_start !== 1'b1) begin n_fail++; $display("FAIL rec_start_pulse: got %0b want 1", rec_start); end
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL rec_state: got %0d want 1", state); end
        n_tests++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rec_we_n: got %0b want 0", sram_we_n); end
        for (int a = 1; a <= 40; a++) begin
            rec_addr = ADDR_W'(a);
            step();
            if (a == 1) begin
                n_tests++; if (rec_start !== 1'b0) begin n_fail++; $display("FAIL rec_start_width: got %0b want 0", rec_start); end
            end
            n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL rec_ramp_state: got %0d want 1 at addr %0d", state, a); end
        end
        press(1'b0, 1'b0, 1'b1);
        n_tests++; if (rec_stop !== 1'b1) begin n_fail++; $display("FAIL rec_stop_pulse: got %0b want 1", rec_stop); end
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL rec_stop_state: got %0d want 0", state); end
        n_tests++; if (rec_len !== 20'd40) begin n_fail++; $display("FAIL rec_len_40: got %0d want 40", rec_len); end
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rec_stop_we_n: got %0b want 1", sram_we_n); end
        step();
        n_tests++; if (rec_stop !== 1'b0) begin n_fail++; $display("FAIL rec_stop_width: got %0b want 0", rec_stop); end
    endtask

    task automatic test_pause_resume();
        mode = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL pr_state1: got %0d want 1", state); end
        press(1'b0, 1'b1, 1'b0);
        n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL pr_state2: got %0d want 2", state); end
        n_tests++; if (rec_pause !== 1'b1) begin n_fail++; $display("FAIL pr_pause_pulse: got %0b want 1", rec_pause); end
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL pr_pause_we_n: got %0b want 1", sram_we_n); end
        step();
        n_tests++; if (rec_pause !== 1'b0) begin n_fail++; $display("FAIL pr_pause_width: got %0b want 0", rec_pause); end
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL pr_resume_state: got %0d want 1", state); end
        n_tests++; if (rec_start !== 1'b1) begin n_fail++; $display("FAIL pr_resume_pulse: got %0b want 1", rec_start); end
        press(1'b0, 1'b0, 1'b1);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL pr_stop_state: got %0d want 0", state); end
        n_tests++; if (rec_stop !== 1'b1) begin n_fail++; $display("FAIL pr_stop_pulse: got %0b want 1", rec_stop); end
        n_tests++; if (rec_len !== 20'd40) begin n_fail++; $display("FAIL pr_rec_len: got %0d want 40", rec_len); end
    endtask

    task automatic test_fast_play();
        mode  = 1'b1;
        fast  = 1'b1;
        speed = 3'd1;
        step();
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL fast_state: got %0d want 3", state); end
        n_tests++; if (play_en !== 1'b1) begin n_fail++; $display("FAIL fast_play_en: got %0b want 1", play_en); end
        n_tests++; if (play_addr !== 20'd0) begin n_fail++; $display("FAIL fast_addr0: got %0d want 0", play_addr); end
        for (int k = 1; k <= 20; k++) begin
            lrc_rise();
            n_tests++; if (play_addr !== ADDR_W'(2 * k)) begin n_fail++; $display("FAIL fast_addr: got %0d want %0d", play_addr, 2 * k); end
        end
        lrc_rise();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL fast_end_state: got %0d want 0", state); end
        n_tests++; if (play_addr !== 20'd0) begin n_fail++; $display("FAIL fast_end_addr: got %0d want 0", play_addr); end
        n_tests++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL fast_end_play_en: got %0b want 0", play_en); end
    endtask

    task automatic test_slow_play();
        mode  = 1'b1;
        fast  = 1'b0;
        speed = 3'd2;
        step();
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL slow_state: got %0d want 3", state); end
        for (int k = 1; k <= 6; k++) begin
            lrc_rise();
            n_tests++; if (play_addr !== ADDR_W'(k / 3)) begin n_fail++; $display("FAIL slow_addr: got %0d want %0d after %0d edges", play_addr, k / 3, k); end
        end
        press(1'b0, 1'b1, 1'b0);
        n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL slow_pause_state: got %0d want 4", state); end
        n_tests++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL slow_pause_play_en: got %0b want 0", play_en); end
        for (int k = 0; k < 10; k++) lrc_rise();
        n_tests++; if (play_addr !== 20'd2) begin n_fail++; $display("FAIL slow_pause_hold: got %0d want 2", play_addr); end
        n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL slow_pause_stay: got %0d want 4", state); end
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL slow_resume_state: got %0d want 3", state); end
        lrc_rise();
        lrc_rise();
        n_tests++; if (play_addr !== 20'd2) begin n_fail++; $display("FAIL slow_resume_hold: got %0d want 2", play_addr); end
        lrc_rise();
        n_tests++; if (play_addr !== 20'd3) begin n_fail++; $display("FAIL slow_resume_step: got %0d want 3", play_addr); end
        press(1'b0, 1'b0, 1'b1);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL slow_stop_state: got %0d want 0", state); end
        n_tests++; if (play_addr !== 20'd0) begin n_fail++; $display("FAIL slow_stop_addr: got %0d want 0", play_addr); end
    endtask

    task automatic test_priority_and_bounds();
        mode     = 1'b0;
        rec_addr = 20'd40;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL prio_ss_state: got %0d want 0", state); end
        n_tests++; if ({rec_start, rec_stop} !== 2'b01) begin n_fail++; $display("FAIL prio_ss_pulses: got %02b want 01", {rec_start, rec_stop}); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL prio_ps_state: got %0d want 0", state); end
        n_tests++; if ({rec_pause, rec_stop} !== 2'b01) begin n_fail++; $display("FAIL prio_ps_pulses: got %02b want 01", {rec_pause, rec_stop}); end
        do_reset();
        mode = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL empty_play_state: got %0d want 0", state); end
        n_tests++; if (play_en !== 1'b0) begin n_fail++; $display("FAIL empty_play_en: got %0b want 0", play_en); end
        mode     = 1'b0;
        rec_addr = 20'd0;
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL max_enter: got %0d want 1", state); end
        rec_addr = 20'hFFFFF;
        step();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL max_state: got %0d want 0", state); end
        n_tests++; if (rec_stop !== 1'b1) begin n_fail++; $display("FAIL max_stop_pulse: got %0b want 1", rec_stop); end
        n_tests++; if (rec_len !== 20'hFFFFF) begin n_fail++; $display("FAIL max_rec_len: got %0h want fffff", rec_len); end
    endtask

    initial begin
        rst       = 1'b1;
        lrc       = 1'b0;
        key_start = 1'b0;
        key_pause = 1'b0;
        key_stop  = 1'b0;
        mode      = 1'b0;
        fast      = 1'b0;
        speed     = '0;
        rec_addr  = '0;
        test_reset();
        test_reset_mid_rec();
        test_record();
        test_pause_resume();
        test_fast_play();
        test_slow_play();
        test_priority_and_bounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
